// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared types and constants for memory_arbiter (MEM_ARB_ROUND_ROBIN_EN)
`timescale 1ns/1ps
package memory_arbiter_pkg;

  // Arbiter FSM encodings
  typedef enum logic [1:0] {
    MEM_ARB_IDLE   = 2'd0,
    MEM_ARB_ACCESS = 2'd1,
    MEM_ARB_WAIT   = 2'd2,
    MEM_ARB_RESP   = 2'd3
  } arb_state_e;

  // Requester identifiers
  localparam logic MEM_PORT_IF   = 1'b0;
  localparam logic MEM_PORT_DATA = 1'b1;

  // Access length codes understood by memoryController
  localparam logic [1:0] MEM_LEN_BYTE = 2'd0;
  localparam logic [1:0] MEM_LEN_HALF = 2'd1;
  localparam logic [1:0] MEM_LEN_WORD = 2'd3;

  // Counter width covering READ_LATENCY up to 7
  localparam int MEM_ARB_CNT_W = 3;

  // One captured memory request as presented to memoryController
  typedef struct packed {
    logic        store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  length;
    logic        is_unsigned;
  } mem_req_t;

  // Fetches are always signed-agnostic word loads with no write data
  function automatic mem_req_t fetch_req(input logic [31:0] addr);
    mem_req_t r;
    r.store       = 1'b0;
    r.addr        = addr;
    r.wdata       = 32'd0;
    r.length      = MEM_LEN_WORD;
    r.is_unsigned = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/memory_arbiter_select.sv
// rtl/memory_arbiter_select.sv - grant decision between fetch and data ports (MEM_ARB_ROUND_ROBIN_EN)
`timescale 1ns/1ps
module memory_arbiter_select
  import memory_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic accept_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic grant_if_o,
  output logic grant_data_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // Under contention the port that did not win last time goes first
  always_comb begin
    grant_data_o = d_req_i && (!if_req_i || (last_grant_q == MEM_PORT_IF));
    grant_if_o   = if_req_i && (!d_req_i || (last_grant_q == MEM_PORT_DATA));
  end

  // Remember the owner of every accepted request; fetch counts as last after reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= MEM_PORT_IF;
    end else if (accept_i) begin
      last_grant_q <= grant_data_o ? MEM_PORT_DATA : MEM_PORT_IF;
    end
  end
`else
  // Fixed priority: data beats fetch, no history kept
  always_comb begin
    grant_data_o = d_req_i;
    grant_if_o   = if_req_i && !d_req_i;
  end

  logic unused_rr_inputs;
  assign unused_rr_inputs = clk ^ reset ^ accept_i;
`endif

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shares memoryController between fetch and data ports (MEM_ARB_ROUND_ROBIN_EN)
`timescale 1ns/1ps
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic        ifReady,
  output logic        ifRespValid,
  output logic [31:0] ifData,
  input  logic        dReq,
  input  logic        dStore,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [1:0]  dLength,
  input  logic        dUnsigned,
  output logic        dReady,
  output logic        dRespValid,
  output logic [31:0] dData,
  output logic [31:0] mcAddress,
  output logic [31:0] mcDataWrite,
  output logic [1:0]  mcLength,
  output logic        mcUnsigned,
  output logic        mcStore,
  output logic        mcLoad,
  input  logic [31:0] mcDataRead
);

  localparam logic [MEM_ARB_CNT_W-1:0] CNT_INIT = MEM_ARB_CNT_W'(READ_LATENCY);

  arb_state_e               state_q;
  logic [MEM_ARB_CNT_W-1:0] cnt_q;
  logic                     owner_q;
  logic                     store_q;
  logic [31:0]              mc_address_q;
  logic [31:0]              mc_data_write_q;
  logic [1:0]               mc_length_q;
  logic                     mc_unsigned_q;
  logic                     mc_store_q;
  logic                     mc_load_q;
  logic                     if_resp_valid_q;
  logic [31:0]              if_data_q;
  logic                     d_resp_valid_q;
  logic [31:0]              d_data_q;

  logic                     grant_if;
  logic                     grant_data;
  logic                     in_idle;
  logic                     accept;
  mem_req_t                 req_d;

  memory_arbiter_select u_select (
    .clk          (clk),
    .reset        (reset),
    .accept_i     (accept),
    .if_req_i     (ifReq),
    .d_req_i      (dReq),
    .grant_if_o   (grant_if),
    .grant_data_o (grant_data)
  );

  // Ready is only offered from IDLE and never while reset is holding the FSM
  assign in_idle = reset && (state_q == MEM_ARB_IDLE);
  assign ifReady = in_idle && grant_if;
  assign dReady  = in_idle && grant_data;
  assign accept  = in_idle && (grant_if || grant_data);

  // Select the fields of the request that wins this cycle
  always_comb begin
    req_d = fetch_req(ifAddr);
    if (grant_data) begin
      req_d = '{store: dStore, addr: dAddr, wdata: dWdata,
                length: dLength, is_unsigned: dUnsigned};
    end
  end

  // Arbiter FSM: capture, strobe, wait for RAM, pulse response
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= MEM_ARB_IDLE;
      cnt_q           <= '0;
      owner_q         <= MEM_PORT_IF;
      store_q         <= 1'b0;
      mc_address_q    <= '0;
      mc_data_write_q <= '0;
      mc_length_q     <= '0;
      mc_unsigned_q   <= 1'b0;
      mc_store_q      <= 1'b0;
      mc_load_q       <= 1'b0;
      if_resp_valid_q <= 1'b0;
      if_data_q       <= '0;
      d_resp_valid_q  <= 1'b0;
      d_data_q        <= '0;
    end else begin
      case (state_q)
        MEM_ARB_IDLE: begin
          if (accept) begin
            owner_q         <= grant_data ? MEM_PORT_DATA : MEM_PORT_IF;
            store_q         <= req_d.store;
            mc_address_q    <= req_d.addr;
            mc_data_write_q <= req_d.wdata;
            mc_length_q     <= req_d.length;
            mc_unsigned_q   <= req_d.is_unsigned;
            mc_store_q      <= req_d.store;
            mc_load_q       <= !req_d.store;
            state_q         <= MEM_ARB_ACCESS;
          end
        end
        MEM_ARB_ACCESS: begin
          mc_store_q <= 1'b0;
          mc_load_q  <= 1'b0;
          if (store_q) begin
            // A store completes as soon as its strobe has been issued
            if (owner_q == MEM_PORT_DATA) begin
              d_data_q       <= '0;
              d_resp_valid_q <= 1'b1;
            end else begin
              if_resp_valid_q <= 1'b1;
            end
            state_q <= MEM_ARB_RESP;
          end else begin
            cnt_q   <= CNT_INIT;
            state_q <= MEM_ARB_WAIT;
          end
        end
        MEM_ARB_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == 1) begin
            // Only the owning port's data register takes the RAM word
            if (owner_q == MEM_PORT_DATA) begin
              d_data_q       <= mcDataRead;
              d_resp_valid_q <= 1'b1;
            end else begin
              if_data_q       <= mcDataRead;
              if_resp_valid_q <= 1'b1;
            end
            state_q <= MEM_ARB_RESP;
          end
        end
        MEM_ARB_RESP: begin
          if_resp_valid_q <= 1'b0;
          d_resp_valid_q  <= 1'b0;
          state_q         <= MEM_ARB_IDLE;
        end
        default: begin
          state_q <= MEM_ARB_IDLE;
        end
      endcase
    end
  end

  assign mcAddress   = mc_address_q;
  assign mcDataWrite = mc_data_write_q;
  assign mcLength    = mc_length_q;
  assign mcUnsigned  = mc_unsigned_q;
  assign mcStore     = mc_store_q;
  assign mcLoad      = mc_load_q;
  assign ifRespValid = if_resp_valid_q;
  assign ifData      = if_data_q;
  assign dRespValid  = d_resp_valid_q;
  assign dData       = d_data_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter (MEM_ARB_ROUND_ROBIN_EN)
`timescale 1ns/1ps
module tb_memory_arbiter;

  localparam int RL  = 1;
  localparam int RL3 = 3;
  localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // DUT with READ_LATENCY=1
  logic        ifReq, ifReady, ifRespValid;
  logic [31:0] ifAddr, ifData;
  logic        dReq, dStore, dUnsigned, dReady, dRespValid;
  logic [31:0] dAddr, dWdata, dData;
  logic [1:0]  dLength;
  logic [31:0] mcAddress, mcDataWrite, mcDataRead;
  logic [1:0]  mcLength;
  logic        mcUnsigned, mcStore, mcLoad;

  // DUT with READ_LATENCY=3
  logic        ifReq3, ifReady3, ifRespValid3;
  logic [31:0] ifAddr3, ifData3;
  logic        dReq3, dStore3, dUnsigned3, dReady3, dRespValid3;
  logic [31:0] dAddr3, dWdata3, dData3;
  logic [1:0]  dLength3;
  logic [31:0] mcAddress3, mcDataWrite3, mcDataRead3;
  logic [1:0]  mcLength3;
  logic        mcUnsigned3, mcStore3, mcLoad3;

  memory_arbiter #(.READ_LATENCY(RL)) u_dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifReady(ifReady), .ifRespValid(ifRespValid), .ifData(ifData),
    .dReq(dReq), .dStore(dStore), .dAddr(dAddr), .dWdata(dWdata), .dLength(dLength),
    .dUnsigned(dUnsigned), .dReady(dReady), .dRespValid(dRespValid), .dData(dData),
    .mcAddress(mcAddress), .mcDataWrite(mcDataWrite), .mcLength(mcLength), .mcUnsigned(mcUnsigned),
    .mcStore(mcStore), .mcLoad(mcLoad), .mcDataRead(mcDataRead)
  );

  memory_arbiter #(.READ_LATENCY(RL3)) u_dut3 (
    .clk(clk), .reset(reset),
    .ifReq(ifReq3), .ifAddr(ifAddr3), .ifReady(ifReady3), .ifRespValid(ifRespValid3), .ifData(ifData3),
    .dReq(dReq3), .dStore(dStore3), .dAddr(dAddr3), .dWdata(dWdata3), .dLength(dLength3),
    .dUnsigned(dUnsigned3), .dReady(dReady3), .dRespValid(dRespValid3), .dData(dData3),
    .mcAddress(mcAddress3), .mcDataWrite(mcDataWrite3), .mcLength(mcLength3), .mcUnsigned(mcUnsigned3),
    .mcStore(mcStore3), .mcLoad(mcLoad3), .mcDataRead(mcDataRead3)
  );

  // Byte-addressed RAM model: fixed initial image plus a write overlay
  logic [7:0] wmem [0:4095];
  bit         wv   [0:4095];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [11:0] i;
    i = a[11:0];
    if (wv[i]) return wmem[i];
    case (i)
      12'h100: return 8'hEF;
      12'h101: return 8'hBE;
      12'h102: return 8'hAD;
      12'h103: return 8'hDE;
      12'h301: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] a, input logic [1:0] len, input logic uns);
    logic [7:0] b0, b1, b2, b3;
    b0 = rd_byte(a);
    b1 = rd_byte(a + 32'd1);
    b2 = rd_byte(a + 32'd2);
    b3 = rd_byte(a + 32'd3);
    case (len)
      2'd0:    return uns ? {24'd0, b0} : {{24{b0[7]}}, b0};
      2'd1:    return uns ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mcStore) begin
      wmem[mcAddress[11:0]] <= mcDataWrite[7:0];
      wv[mcAddress[11:0]]   <= 1'b1;
      if (mcLength != 2'd0) begin
        wmem[12'(mcAddress[11:0] + 12'd1)] <= mcDataWrite[15:8];
        wv[12'(mcAddress[11:0] + 12'd1)]   <= 1'b1;
      end
      if (mcLength == 2'd3) begin
        wmem[12'(mcAddress[11:0] + 12'd2)] <= mcDataWrite[23:16];
        wv[12'(mcAddress[11:0] + 12'd2)]   <= 1'b1;
        wmem[12'(mcAddress[11:0] + 12'd3)] <= mcDataWrite[31:24];
        wv[12'(mcAddress[11:0] + 12'd3)]   <= 1'b1;
      end
    end
  end

  // Read pipelines: data valid for exactly one cycle, READ_LATENCY cycles after the load strobe
  logic [31:0] pd1 [0:7];
  bit          pv1 [0:7];
  logic [31:0] pd3 [0:7];
  bit          pv3 [0:7];
  always @(posedge clk) begin
    pv1[0] <= mcLoad;
    pd1[0] <= ld_val(mcAddress, mcLength, mcUnsigned);
    pv3[0] <= mcLoad3;
    pd3[0] <= ld_val(mcAddress3, mcLength3, mcUnsigned3);
    for (int i = 1; i < 8; i++) begin
      pv1[i] <= pv1[i-1];
      pd1[i] <= pd1[i-1];
      pv3[i] <= pv3[i-1];
      pd3[i] <= pd3[i-1];
    end
  end
  assign mcDataRead  = pv1[RL-1]  ? pd1[RL-1]  : JUNK;
  assign mcDataRead3 = pv3[RL3-1] ? pd3[RL3-1] : JUNK;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected responses
  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } sb_t;
  sb_t sb[$];
  sb_t e;
  bit          mon_en = 1'b0;
  logic [31:0] last_if = '0;
  logic [31:0] last_d  = '0;

  always @(negedge clk) begin
    if (mon_en && (ifRespValid || dRespValid)) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {62'd0, ifRespValid, dRespValid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_port", {62'd0, ifRespValid, dRespValid}, e.port ? 64'd1 : 64'd2);
        chk("resp_cycle", 64'(cyc), 64'(e.due));
        if (e.port) begin
          chk("dData", 64'(dData), 64'(e.data));
          chk("ifData_held", 64'(ifData), 64'(last_if));
          last_d = e.data;
        end else begin
          chk("ifData", 64'(ifData), 64'(e.data));
          chk("dData_held", 64'(dData), 64'(last_d));
          last_if = e.data;
        end
      end
    end
  end

  typedef struct {
    bit          port;
    bit          store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  len;
    bit          uns;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [12];

  task automatic do_req(input vec_t v);
    int g;
    bit ok;
    @(posedge clk); #1;
    if (v.port) begin
      dReq = 1'b1; dStore = v.store; dAddr = v.addr; dWdata = v.wdata;
      dLength = v.len; dUnsigned = v.uns;
    end else begin
      ifReq = 1'b1; ifAddr = v.addr;
    end
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (v.port ? dReady : ifReady) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 64'(ok), 64'd1);
    if (!ok) begin
      ifReq = 1'b0; dReq = 1'b0;
      return;
    end
    g = cyc;
    sb.push_back('{v.port, v.exp, g + (v.store ? 2 : RL + 2)});
    @(posedge clk); #1;
    ifReq = 1'b0; dReq = 1'b0;
    @(negedge clk);
    chk("mc_strobe", {62'd0, mcStore, mcLoad}, v.store ? 64'd2 : 64'd1);
    chk("mc_fields", {29'd0, mcAddress, mcLength, mcUnsigned},
        {29'd0, v.addr, v.port ? v.len : 2'b11, v.port ? v.uns : 1'b0});
    chk("mc_wdata", 64'(mcDataWrite), v.port ? 64'(v.wdata) : 64'd0);
    @(negedge clk);
    chk("mc_strobe_off", {62'd0, mcStore, mcLoad}, 64'd0);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // Both ports request loads together; rearm keeps both asserted across grants
  task automatic contention(input int n, input bit rearm);
    int  g, prev;
    bit  ok, p;
    @(posedge clk); #1;
    ifReq = 1'b1; ifAddr = 32'h100;
    dReq = 1'b1; dStore = 1'b0; dAddr = 32'h300; dWdata = 32'd0; dLength = 2'd3; dUnsigned = 1'b0;
    prev = -1;
    for (int i = 0; i < n; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (ifReady || dReady) begin
          ok = 1'b1;
          break;
        end
      end
      chk("cont_accept", 64'(ok), 64'd1);
      if (!ok) break;
      p = dReady;
      chk("grant_order", 64'(p), (i % 2 == 0) ? 64'd1 : 64'd0);
      g = cyc;
      if (prev >= 0) chk("grant_gap", 64'(g - prev), 64'(RL + 3));
      prev = g;
      sb.push_back('{p, p ? 32'h0000_8000 : 32'hDEAD_BEEF, g + RL + 2});
      @(posedge clk); #1;
      if (!rearm) begin
        if (p) dReq = 1'b0;
        else ifReq = 1'b0;
      end
    end
    ifReq = 1'b0; dReq = 1'b0;
  endtask

  task automatic rl3_load(input bit port, input logic [31:0] addr, input logic [1:0] len,
                          input bit uns, input logic [31:0] exp);
    int g, seen;
    bit ok;
    @(posedge clk); #1;
    if (port) begin
      dReq3 = 1'b1; dStore3 = 1'b0; dAddr3 = addr; dLength3 = len; dUnsigned3 = uns;
    end else begin
      ifReq3 = 1'b1; ifAddr3 = addr;
    end
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (port ? dReady3 : ifReady3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rl3_accept", 64'(ok), 64'd1);
    if (!ok) begin
      ifReq3 = 1'b0; dReq3 = 1'b0;
      return;
    end
    g = cyc;
    @(posedge clk); #1;
    ifReq3 = 1'b0; dReq3 = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ifRespValid3 || dRespValid3) begin
        seen++;
        chk("rl3_resp_cycle", 64'(cyc), 64'(g + RL3 + 2));
        chk("rl3_resp_port", {62'd0, ifRespValid3, dRespValid3}, port ? 64'd1 : 64'd2);
        chk("rl3_data", port ? 64'(dData3) : 64'(ifData3), 64'(exp));
      end
    end
    chk("rl3_pulses", 64'(seen), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time %0t exceeded, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int  g;
    bit  ok;
    vt[0]  = '{0, 0, 32'h100, 32'h0,        2'd3, 0, 32'hDEAD_BEEF};
    vt[1]  = '{1, 1, 32'h203, 32'h0000_00AB, 2'd0, 0, 32'h0};
    vt[2]  = '{1, 0, 32'h203, 32'h0,        2'd0, 1, 32'h0000_00AB};
    vt[3]  = '{1, 0, 32'h300, 32'h0,        2'd3, 0, 32'h0000_8000};
    vt[4]  = '{1, 0, 32'h300, 32'h0,        2'd1, 0, 32'hFFFF_8000};
    vt[5]  = '{1, 0, 32'h300, 32'h0,        2'd1, 1, 32'h0000_8000};
    vt[6]  = '{1, 1, 32'h500, 32'hCAFE_F00D, 2'd3, 0, 32'h0};
    vt[7]  = '{0, 0, 32'h500, 32'h0,        2'd3, 0, 32'hCAFE_F00D};
    vt[8]  = '{1, 1, 32'h503, 32'h0000_1234, 2'd1, 0, 32'h0};
    vt[9]  = '{1, 0, 32'h500, 32'h0,        2'd3, 0, 32'h34FE_F00D};
    vt[10] = '{1, 0, 32'h301, 32'h0,        2'd0, 0, 32'hFFFF_FF80};
    vt[11] = '{0, 0, 32'h504, 32'h0,        2'd3, 0, 32'h0000_0012};

    reset = 1'b0;
    ifReq = 1'b0; ifAddr = '0; dReq = 1'b0; dStore = 1'b0; dAddr = '0; dWdata = '0;
    dLength = '0; dUnsigned = 1'b0;
    ifReq3 = 1'b0; ifAddr3 = '0; dReq3 = 1'b0; dStore3 = 1'b0; dAddr3 = '0; dWdata3 = '0;
    dLength3 = '0; dUnsigned3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_resp", {62'd0, ifRespValid, dRespValid}, 64'd0);
    chk("reset_data", {ifData, dData}, 64'd0);
    chk("reset_mc_addr_wdata", {mcAddress, mcDataWrite}, 64'd0);
    chk("reset_mc_ctl", {59'd0, mcLength, mcUnsigned, mcStore, mcLoad}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) do_req(vt[i]);
    wait_drain();

`ifdef MEM_ARB_ROUND_ROBIN_EN
    contention(4, 1'b1);
`else
    contention(2, 1'b0);
`endif
    wait_drain();

    // Reset asserted while the load is in WAIT: the access is dropped silently
    @(posedge clk); #1;
    dReq = 1'b1; dStore = 1'b0; dAddr = 32'h300; dLength = 2'd3; dUnsigned = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dReady) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_accept", 64'(ok), 64'd1);
    g = cyc;
    @(posedge clk); #1;
    dReq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_wait_cycle", 64'(cyc), 64'(g + 2));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_no_resp", {60'd0, ifRespValid, dRespValid, mcStore, mcLoad}, 64'd0);
    chk("rst_data_cleared", {dData, ifData}, 64'd0);
    chk("rst_mc_addr", 64'(mcAddress), 64'd0);
    last_if = '0;
    last_d  = '0;
    repeat (3) @(negedge clk);
    do_req('{1, 0, 32'h100, 32'h0, 2'd3, 0, 32'hDEAD_BEEF});
    wait_drain();

    rl3_load(1'b1, 32'h301, 2'd0, 1'b0, 32'hFFFF_FF80);
    rl3_load(1'b0, 32'h100, 2'd3, 1'b0, 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
